// File: rtl/therm_n1_mem_pkg.sv
// Shared types and widths for the fetch/LSU memory arbiter slice.
package therm_n1_mem_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned GNT_FETCH = 0;
  localparam int unsigned GNT_LSU   = 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ERR} arb_state_e;
  typedef enum logic {OWN_FETCH, OWN_LSU} owner_e;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/therm_n1_mem_grant.sv
// Fixed LSU-priority select with a fetch starvation guard.
module therm_n1_mem_grant
  import therm_n1_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset_neg,
  input  logic       idle,
  input  logic       fetch_valid,
  input  logic       lsu_valid,
  output logic [1:0] grant
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             grant_fetch;

  always_comb begin
    starved            = starve_cnt >= CNT_W'(STARVE_LIMIT);
    grant_fetch        = fetch_valid && (!lsu_valid || starved);
    grant              = '0;
    grant[GNT_FETCH]   = grant_fetch;
    grant[GNT_LSU]     = lsu_valid && !grant_fetch;
  end

  // Only IDLE-state arbitrations count as lost; the count saturates at the limit.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      starve_cnt <= '0;
    end else if (idle && fetch_valid) begin
      if (grant_fetch)  starve_cnt <= '0;
      else if (!starved) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/therm_n1_memory_arbiter.sv
// Serialises fetch and LSU accesses onto the single-port memory, one access outstanding.
module therm_n1_memory_arbiter
  import therm_n1_mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_neg,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_flush,
  output logic              fetch_rsp_valid,
  output logic [WORD_W-1:0] fetch_rsp_data,
  output logic              fetch_rsp_error,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_req_write,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [WORD_W-1:0] lsu_wdata,
  output logic              lsu_rsp_valid,
  output logic [WORD_W-1:0] lsu_rsp_data,
  output logic              lsu_rsp_error,
  output logic              mem_chip_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_data_store,
  input  logic [WORD_W-1:0] mem_data_load
);

  localparam logic [1:0] WAIT_LAST = (MEM_LATENCY > 1) ? 2'(MEM_LATENCY - 2) : 2'd0;

  arb_state_e        state_q, state_d;
  owner_e            owner_q, pend_owner_q;
  logic              wr_q, drop_q, pend_q, pend_drop_q, pend_wr_q;
  logic [1:0]        wait_q;
  logic [1:0]        grant;
  logic              idle, hs, mis, done, drop_now;
  logic [ADDR_W-1:0] sel_addr;

  therm_n1_mem_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .clock       (clock),
    .reset_neg   (reset_neg),
    .idle        (idle),
    .fetch_valid (fetch_req_valid),
    .lsu_valid   (lsu_req_valid),
    .grant       (grant)
  );

  assign idle             = state_q == IDLE;
  assign fetch_req_ready  = idle && grant[GNT_FETCH];
  assign lsu_req_ready    = idle && grant[GNT_LSU];
  assign hs               = fetch_req_ready || lsu_req_ready;
  assign sel_addr         = grant[GNT_LSU] ? lsu_addr : fetch_addr;
  assign mis              = is_misaligned(sel_addr[1:0]);
  assign drop_now         = drop_q || (fetch_flush && owner_q == OWN_FETCH);
  assign mem_chip_enable  = state_q == ACCESS;
  assign mem_write_enable = (state_q == ACCESS) && wr_q;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE:   if (hs) state_d = mis ? ERR : ACCESS;
      ACCESS: begin
        if (MEM_LATENCY <= 1) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load data is captured one edge after the access leaves ACCESS/WAIT, once the
  // memory output is stable; the arbiter is already back in IDLE during that cycle.
  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      state_q         <= IDLE;
      owner_q         <= OWN_FETCH;
      wr_q            <= 1'b0;
      drop_q          <= 1'b0;
      wait_q          <= '0;
      pend_q          <= 1'b0;
      pend_drop_q     <= 1'b0;
      pend_owner_q    <= OWN_FETCH;
      pend_wr_q       <= 1'b0;
      mem_address     <= '0;
      mem_data_store  <= '0;
      fetch_rsp_valid <= 1'b0;
      fetch_rsp_data  <= '0;
      fetch_rsp_error <= 1'b0;
      lsu_rsp_valid   <= 1'b0;
      lsu_rsp_data    <= '0;
      lsu_rsp_error   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        owner_q <= grant[GNT_LSU] ? OWN_LSU : OWN_FETCH;
        drop_q  <= 1'b0;
        if (!mis) begin
          wr_q        <= grant[GNT_LSU] && lsu_req_write;
          mem_address <= sel_addr;
          if (grant[GNT_LSU]) mem_data_store <= lsu_wdata;
        end
      end else if (!idle && fetch_flush && owner_q == OWN_FETCH) begin
        drop_q <= 1'b1;
      end

      if (state_q == ACCESS)    wait_q <= '0;
      else if (state_q == WAIT) wait_q <= wait_q + 1'b1;

      pend_q       <= done;
      pend_drop_q  <= drop_now;
      pend_owner_q <= owner_q;
      pend_wr_q    <= wr_q;

      fetch_rsp_valid <= 1'b0;
      lsu_rsp_valid   <= 1'b0;
      if (pend_q) begin
        if (pend_owner_q == OWN_FETCH) begin
          if (!pend_drop_q) begin
            fetch_rsp_valid <= 1'b1;
            fetch_rsp_data  <= mem_data_load;
            fetch_rsp_error <= 1'b0;
          end
        end else begin
          lsu_rsp_valid <= 1'b1;
          lsu_rsp_error <= 1'b0;
          if (!pend_wr_q) lsu_rsp_data <= mem_data_load;
        end
      end
      if (state_q == ERR) begin
        if (owner_q == OWN_FETCH) begin
          if (!drop_now) begin
            fetch_rsp_valid <= 1'b1;
            fetch_rsp_error <= 1'b1;
          end
        end else begin
          lsu_rsp_valid <= 1'b1;
          lsu_rsp_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_therm_n1_memory_arbiter.sv
// Directed scoreboard bench for the fetch/LSU memory arbiter with a latency-1 memory model.
module tb_therm_n1_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset_neg = 1'b0;
  logic        fetch_req_valid = 1'b0, fetch_req_ready, fetch_flush = 1'b0;
  logic [63:0] fetch_addr = '0;
  logic        fetch_rsp_valid, fetch_rsp_error;
  logic [31:0] fetch_rsp_data;
  logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_req_write = 1'b0;
  logic [63:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_rsp_valid, lsu_rsp_error;
  logic [31:0] lsu_rsp_data;
  logic        mem_chip_enable, mem_write_enable;
  logic [63:0] mem_address;
  logic [31:0] mem_data_store;
  logic [31:0] mem_data_load = '0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        fq[$];
  exp_t        lq[$];
  exp_t        fe, le;
  int          compared = 0, mismatched = 0;
  int          cyc = 0, ce_cnt = 0, we_cnt = 0;
  logic [31:0] mem_arr[logic [63:0]];
  logic [31:0] ref_mem[logic [63:0]];
  logic [31:0] last_fetch = '0, last_lsu = '0;

  therm_n1_memory_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset_neg(reset_neg),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data),
    .fetch_rsp_error(fetch_rsp_error),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_write(lsu_req_write), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .lsu_rsp_error(lsu_rsp_error),
    .mem_chip_enable(mem_chip_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_data_store(mem_data_store),
    .mem_data_load(mem_data_load)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_chip_enable === 1'b1) begin
      ce_cnt <= ce_cnt + 1;
      if (mem_write_enable === 1'b1) begin
        we_cnt <= we_cnt + 1;
        mem_arr[mem_address] = mem_data_store;
      end else begin
        mem_data_load <= mem_arr.exists(mem_address) ? mem_arr[mem_address] : 32'h0;
      end
    end
  end

  function automatic logic [31:0] ref_read(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  always @(negedge clock) begin
    if (reset_neg === 1'b1 && fetch_rsp_valid === 1'b1) begin
      compared++;
      assert (fq.size() > 0) else begin
        mismatched++;
        $error("FAIL fetch_unexpected_rsp observed data=%h expected no response", fetch_rsp_data);
      end
      if (fq.size() > 0) begin
        fe = fq.pop_front();
        compared++;
        assert ({fetch_rsp_error, fetch_rsp_data} === {fe.err, fe.data}) else begin
          mismatched++;
          $error("FAIL fetch_rsp observed err=%b data=%h expected err=%b data=%h",
                 fetch_rsp_error, fetch_rsp_data, fe.err, fe.data);
        end
        compared++;
        assert (cyc === fe.due) else begin
          mismatched++;
          $error("FAIL fetch_latency observed cycle=%0d expected cycle=%0d", cyc, fe.due);
        end
      end
    end
    if (reset_neg === 1'b1 && lsu_rsp_valid === 1'b1) begin
      compared++;
      assert (lq.size() > 0) else begin
        mismatched++;
        $error("FAIL lsu_unexpected_rsp observed data=%h expected no response", lsu_rsp_data);
      end
      if (lq.size() > 0) begin
        le = lq.pop_front();
        compared++;
        assert ({lsu_rsp_error, lsu_rsp_data} === {le.err, le.data}) else begin
          mismatched++;
          $error("FAIL lsu_rsp observed err=%b data=%h expected err=%b data=%h",
                 lsu_rsp_error, lsu_rsp_data, le.err, le.data);
        end
        compared++;
        assert (cyc === le.due) else begin
          mismatched++;
          $error("FAIL lsu_latency observed cycle=%0d expected cycle=%0d", cyc, le.due);
        end
      end
    end
  end

  // Returns just after the handshake edge, with the request valid dropped.
  task automatic do_req(input bit lsu, input bit wr, input logic [63:0] addr,
                        input logic [31:0] wd, input bit expect_rsp);
    bit   got;
    bit   mis;
    exp_t e;
    @(negedge clock);
    if (lsu) begin
      lsu_req_valid = 1'b1; lsu_req_write = wr; lsu_addr = addr; lsu_wdata = wd;
    end else begin
      fetch_req_valid = 1'b1; fetch_addr = addr;
    end
    #1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if ((lsu ? lsu_req_ready : fetch_req_ready) === 1'b1) got = 1'b1;
      else begin @(negedge clock); #1; end
    end
    compared++;
    assert (got) else begin
      mismatched++;
      $error("FAIL req_timeout observed ready=0 expected ready=1 addr=%h", addr);
    end
    mis   = addr[1:0] != 2'b00;
    e.err = mis;
    e.due = cyc + (mis ? 2 : 3);
    if (lsu) begin
      if (!mis && !wr) last_lsu = ref_read(addr);
      if (!mis && wr) ref_mem[addr] = wd;
      e.data = last_lsu;
      if (expect_rsp && got) lq.push_back(e);
    end else begin
      if (!mis) last_fetch = ref_read(addr);
      e.data = last_fetch;
      if (expect_rsp && got) fq.push_back(e);
    end
    @(posedge clock); #1;
    fetch_req_valid = 1'b0;
    lsu_req_valid   = 1'b0;
    lsu_req_write   = 1'b0;
  endtask

  initial begin
    int   base;
    int   n;
    bit   exp_lsu;
    exp_t e;

    mem_arr[64'h40]  = 32'h0000_0013;  ref_mem[64'h40]  = 32'h0000_0013;
    mem_arr[64'h204] = 32'h0010_0093;  ref_mem[64'h204] = 32'h0010_0093;
    mem_arr[64'h200] = 32'hAAAA_5555;  ref_mem[64'h200] = 32'hAAAA_5555;

    repeat (3) @(negedge clock);
    reset_neg = 1'b1;

    // Async reset mid-ACCESS abandons the fetch.
    do_req(1'b0, 1'b0, 64'h40, '0, 1'b0);
    compared++;
    assert (mem_chip_enable === 1'b1) else begin
      mismatched++;
      $error("FAIL access_before_reset observed ce=%b expected ce=1", mem_chip_enable);
    end
    #1 reset_neg = 1'b0;
    #1;
    compared++;
    assert ({fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_error,
             lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_error,
             mem_chip_enable, mem_write_enable, mem_address, mem_data_store} === '0) else begin
      mismatched++;
      $error("FAIL reset_outputs observed addr=%h ce=%b expected all zero", mem_address, mem_chip_enable);
    end
    last_fetch = '0;
    last_lsu   = '0;
    repeat (2) @(negedge clock);
    reset_neg = 1'b1;
    repeat (4) @(negedge clock);

    do_req(1'b0, 1'b0, 64'h40, '0, 1'b1);
    repeat (3) @(negedge clock);

    base = we_cnt;
    do_req(1'b1, 1'b1, 64'h100, 32'hDEAD_BEEF, 1'b1);
    repeat (3) @(negedge clock);
    compared++;
    assert (we_cnt - base === 1) else begin
      mismatched++;
      $error("FAIL store_we_cycles observed=%0d expected=1", we_cnt - base);
    end
    do_req(1'b1, 1'b0, 64'h100, '0, 1'b1);
    repeat (3) @(negedge clock);

    // Flush during ACCESS: memory still accessed, response dropped.
    base = ce_cnt;
    do_req(1'b0, 1'b0, 64'h200, '0, 1'b0);
    last_fetch  = 32'h0000_0013;
    fetch_flush = 1'b1;
    @(posedge clock); #1;
    fetch_flush = 1'b0;
    repeat (3) @(negedge clock);
    compared++;
    assert (ce_cnt - base === 1) else begin
      mismatched++;
      $error("FAIL flush_ce_pulses observed=%0d expected=1", ce_cnt - base);
    end
    do_req(1'b0, 1'b0, 64'h204, '0, 1'b1);
    repeat (3) @(negedge clock);

    base = ce_cnt;
    do_req(1'b1, 1'b0, 64'h102, '0, 1'b1);
    repeat (3) @(negedge clock);
    compared++;
    assert (ce_cnt - base === 0) else begin
      mismatched++;
      $error("FAIL misaligned_ce_pulses observed=%0d expected=0", ce_cnt - base);
    end

    // Both requesters held valid: LSU x4 then fetch x1, repeating.
    @(negedge clock);
    fetch_req_valid = 1'b1; fetch_addr = 64'h40;
    lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_addr = 64'h100;
    #1;
    n = 0;
    for (int i = 0; i < 60 && n < 10; i++) begin
      if (fetch_req_ready === 1'b1 || lsu_req_ready === 1'b1) begin
        exp_lsu = (n % 5) != 4;
        compared++;
        assert ({lsu_req_ready, fetch_req_ready} === {exp_lsu, !exp_lsu}) else begin
          mismatched++;
          $error("FAIL starve_grant_%0d observed lsu/fetch=%b%b expected %b%b",
                 n, lsu_req_ready, fetch_req_ready, exp_lsu, !exp_lsu);
        end
        e.err = 1'b0;
        e.due = cyc + 3;
        if (exp_lsu) begin
          last_lsu = ref_read(64'h100); e.data = last_lsu; lq.push_back(e);
        end else begin
          last_fetch = ref_read(64'h40); e.data = last_fetch; fq.push_back(e);
        end
        n++;
      end
      if (n < 10) begin @(negedge clock); #1; end
    end
    compared++;
    assert (n === 10) else begin
      mismatched++;
      $error("FAIL starve_timeout observed grants=%0d expected=10", n);
    end
    @(posedge clock); #1;
    fetch_req_valid = 1'b0;
    lsu_req_valid   = 1'b0;

    repeat (10) @(negedge clock);
    compared++;
    assert (fq.size() === 0) else begin
      mismatched++;
      $error("FAIL fetch_missing_rsp observed pending=%0d expected=0", fq.size());
    end
    compared++;
    assert (lq.size() === 0) else begin
      mismatched++;
      $error("FAIL lsu_missing_rsp observed pending=%0d expected=0", lq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
